// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Branch targets are word addresses; the low two bits carry no meaning.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/acknowledge bus between fetch stage and memory.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_hold,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;

  // Pipeline register update with flush/hold/load priority.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_valid <= r_valid;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, stall/redirect handling, IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        inclk,
  input  logic        inrst_n,
  fetch_if.master     imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_hold_instr;
  logic [31:0]  r_pending;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_pc_inc;
  logic [31:0]  w_redir_pc;
  logic [31:0]  w_ifid_instr;
  logic         w_ifid_load;
  logic         w_hold_ld;
  logic         w_pend_ld;

  assign w_redir_pc = align_word(redirect_pc);
  assign w_pc_inc   = r_pc + PC_INC;

  // State register.
  always_ff @(posedge inclk) begin
    if (!inrst_n) begin
      r_state <= REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a redirect always wins over a stall.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      REQ: begin
        if (imem.imem_ack) begin
          if (redirect)   w_state_nxt = REQ;
          else if (stall) w_state_nxt = HOLD;
          else            w_state_nxt = REQ;
        end else if (redirect) begin
          w_state_nxt = SQUASH;
        end else begin
          w_state_nxt = REQ;
        end
      end
      SQUASH: begin
        if (imem.imem_ack) w_state_nxt = REQ;
        else               w_state_nxt = SQUASH;
      end
      HOLD: begin
        if (redirect || !stall) w_state_nxt = REQ;
        else                    w_state_nxt = HOLD;
      end
      default: w_state_nxt = REQ;
    endcase
  end

  // Datapath controls: PC update, hold/pending capture and IF/ID load.
  always_comb begin
    w_pc_nxt     = r_pc;
    w_ifid_load  = 1'b0;
    w_hold_ld    = 1'b0;
    w_pend_ld    = 1'b0;
    w_ifid_instr = (r_state == HOLD) ? r_hold_instr : imem.imem_rdata;
    case (r_state)
      REQ: begin
        if (imem.imem_ack) begin
          if (redirect) begin
            w_pc_nxt = w_redir_pc;
          end else if (!stall) begin
            w_pc_nxt    = w_pc_inc;
            w_ifid_load = 1'b1;
          end else begin
            w_hold_ld = 1'b1;
          end
        end else if (redirect) begin
          w_pend_ld = 1'b1;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      SQUASH: begin
        // The in-flight fetch is obsolete; wait for its ack before moving the PC.
        if (imem.imem_ack) begin
          w_pc_nxt = redirect ? w_redir_pc : r_pending;
        end else if (redirect) begin
          w_pend_ld = 1'b1;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_pc_nxt = w_redir_pc;
        end else if (!stall) begin
          w_pc_nxt    = w_pc_inc;
          w_ifid_load = 1'b1;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      default: w_pc_nxt = r_pc;
    endcase
  end

  // PC, held instruction and pending redirect target.
  always_ff @(posedge inclk) begin
    if (!inrst_n) begin
      r_pc         <= RESET_PC;
      r_hold_instr <= 32'd0;
      r_pending    <= 32'd0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_hold_ld) r_hold_instr <= imem.imem_rdata;
      else           r_hold_instr <= r_hold_instr;
      if (w_pend_ld) r_pending <= w_redir_pc;
      else           r_pending <= r_pending;
    end
  end

  assign imem.imem_req  = inrst_n && (r_state != HOLD);
  assign imem.imem_addr = r_pc;
  assign pc             = r_pc;

  ifid_reg u_ifid (
    .i_clk   (inclk),
    .i_rst_n (inrst_n),
    .i_flush (redirect),
    .i_hold  (stall),
    .i_load  (w_ifid_load),
    .i_instr (w_ifid_instr),
    .i_pc4   (w_pc_inc),
    .o_valid (ifid_valid),
    .o_instr (ifid_instr),
    .o_pc4   (ifid_pc4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences, random vs. model.
module tb_fetch_stage;

  logic        inclk;
  logic        inrst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;

  fetch_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .inclk       (inclk),
    .inrst_n     (inrst_n),
    .imem        (bus.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e_pc, input logic e_req,
                            input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc4);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".req"}, {31'd0, bus.imem_req}, {31'd0, e_req});
    chk({tag, ".addr"}, bus.imem_addr, e_pc);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
    if (e_valid) begin
      chk({tag, ".instr"}, ifid_instr, e_instr);
      chk({tag, ".pc4"}, ifid_pc4, e_pc4);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, return 1 time unit after it.
  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic ack, input logic [31:0] rdata);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    bus.imem_ack   = ack;
    bus.imem_rdata = rdata;
    @(posedge inclk);
    #1;
  endtask

  task automatic apply_reset();
    inrst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
    for (int k = 0; k < 2; k++) begin
      @(posedge inclk);
      #1;
      chk("rst.pc", pc, 32'h0000_0000);
      chk("rst.valid", {31'd0, ifid_valid}, 32'd0);
      chk("rst.req", {31'd0, bus.imem_req}, 32'd0);
    end
    inrst_n = 1'b1;
    #1;
    chk("rel.req", {31'd0, bus.imem_req}, 32'd1);
    chk("rel.addr", bus.imem_addr, 32'h0000_0000);
  endtask

  // Reference model: PC, IF/ID contents, a queue for a stalled instruction,
  // and a flag marking an in-flight fetch made obsolete by a redirect.
  logic [31:0] m_pc, m_target, m_instr, m_pc4;
  logic        m_valid, m_obsolete;
  logic [31:0] m_held[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_target = 32'd0; m_valid = 1'b0; m_obsolete = 1'b0;
    m_instr = 32'd0; m_pc4 = 32'd0;
    m_held.delete();
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc,
                            input logic ack, input logic [31:0] rdata);
    logic [31:0] tgt;
    logic        have;
    logic [31:0] word;
    tgt  = {rpc[31:2], 2'b00};
    have = 1'b0;
    word = 32'd0;
    if (m_held.size() != 0) begin
      if (rd) begin
        m_held.delete();
        m_pc = tgt;
      end else if (!st) begin
        have = 1'b1; word = m_held.pop_front();
      end
    end else if (ack) begin
      if (m_obsolete) begin
        m_obsolete = 1'b0;
        m_pc = rd ? tgt : m_target;
      end else if (rd) begin
        m_pc = tgt;
      end else if (!st) begin
        have = 1'b1; word = rdata;
      end else begin
        m_held.push_back(rdata);
      end
    end else if (rd) begin
      m_obsolete = 1'b1;
      m_target = tgt;
    end
    if (rd) m_valid = 1'b0;
    else if (st) m_valid = m_valid;
    else if (have) begin
      m_valid = 1'b1; m_instr = word; m_pc4 = m_pc + 32'd4;
    end else m_valid = 1'b0;
    if (have) m_pc = m_pc + 32'd4;
  endtask

  initial begin
    // stall, redir, rpc, ack, rdata, exp pc, exp req, exp valid, exp instr, exp pc4
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h4,   1'b1, 1'b1, 32'h0,   32'h4};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h8,   1'b1, 1'b1, 32'h4,   32'h8};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h8,   1'b0, 1'b1, 32'h4,   32'h8};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h8,   1'b0, 1'b1, 32'h4,   32'h8};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h8,   1'b0, 1'b1, 32'h4,   32'h8};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'hC,   1'b1, 1'b1, 32'h8,   32'hC};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   32'h10,  1'b1, 1'b1, 32'hC,   32'h10};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h10,  1'b1, 1'b0, 32'h0,   32'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'h20,  1'b1, 32'h10,  32'h20,  1'b1, 1'b0, 32'h0,   32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h203, 1'b1, 32'h20,  32'h200, 1'b1, 1'b0, 32'h0,   32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 32'h204, 1'b1, 1'b1, 32'h200, 32'h204};
    vecs[11] = '{1'b0, 1'b1, 32'h40,  1'b0, 32'h0,   32'h204, 1'b1, 1'b0, 32'h0,   32'h0};
    vecs[12] = '{1'b0, 1'b1, 32'h80,  1'b0, 32'h0,   32'h204, 1'b1, 1'b0, 32'h0,   32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 32'h80,  1'b1, 1'b0, 32'h0,   32'h0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  32'h84,  1'b1, 1'b1, 32'h80,  32'h84};

    apply_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
      check_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_req, vecs[i].e_valid,
                 vecs[i].e_instr, vecs[i].e_pc4);
    end

    // Reset while the request at 0x84 is still waiting for its ack.
    apply_reset();

    // Two-wait fetch at 0x10 squashed by a redirect to 0x100.
    cyc(1'b0, 1'b1, 32'h10, 1'b1, 32'h0);
    check_outs("sq0", 32'h10, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_outs("sq1", 32'h10, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    check_outs("sq2", 32'h10, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    check_outs("sq3", 32'h100, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    check_outs("sq4", 32'h104, 1'b1, 1'b1, 32'h100, 32'h104);

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0);
    check_outs("wrap0", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    check_outs("wrap1", 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0);

    // Randomized run against the reference model with a variable-latency memory.
    apply_reset();
    model_reset();
    begin
      int          wait_left;
      logic        st, rd, ack;
      logic [31:0] rpc, rdata;
      wait_left = int'($urandom_range(0, 3));
      for (int c = 0; c < 3000; c++) begin
        check_outs("rnd", m_pc, (m_held.size() == 0), m_valid, m_instr, m_pc4);
        st  = ($urandom_range(0, 3) == 0);
        rd  = ($urandom_range(0, 9) == 0);
        rpc = $urandom;
        ack = 1'b0;
        rdata = $urandom;
        if (m_held.size() == 0) begin
          if (wait_left == 0) begin
            ack = 1'b1;
            rdata = mem_word(m_pc);
            wait_left = int'($urandom_range(0, 3));
          end else begin
            wait_left--;
          end
        end
        model_step(st, rd, rpc, ack, rdata);
        cyc(st, rd, rpc, ack, rdata);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with IF/ID pipeline register for the five-stage MIPS datapath. Holds the PC and issues requests to the instruction memory over a req/ack handshake. Registers each fetched instruction with its PC+4 into IF/ID for the decode stage. Applies decode-stage stalls and branch redirects from EX/MEM, discarding any in-flight fetch made obsolete by a redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- inclk  in  1  clock; all state updates on rising edge
- inrst_n  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals pc
- imem_ack  in  1  memory response valid; may assert in the same cycle as req
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- stall  in  1  hazard unit: IF/ID must hold its contents; PC must not advance
- redirect  in  1  branch taken (zero flag AND branch) from EX/MEM
- redirect_pc  in  32  branch target; bits [1:0] ignored and forced to 0
- pc  out  32  current fetch PC
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- ifid_instr  out  32  IF/ID instruction
- ifid_pc4  out  32  IF/ID PC+4

## Operation
- Reset (inrst_n=0 at an edge): pc=RESET_PC, state=REQ, ifid_valid=0, ifid_instr=0, ifid_pc4=0, hold and pending registers=0. imem_req is gated to 0 while inrst_n=0. Instruction memory shares this reset; no ack from before reset is honoured.
- imem_req=1 in REQ and SQUASH; 0 in HOLD. imem_addr must stay stable while req=1 until ack.
- REQ, ack=1:
  - redirect=1: discard rdata; pc←redirect_pc; stay REQ.
  - else stall=0: IF/ID←{1, rdata, pc+4}; pc←pc+4; stay REQ.
  - else (stall=1): hold_instr←rdata; go HOLD.
- REQ, ack=0:
  - redirect=1: pending←redirect_pc; go SQUASH.
  - else: stay REQ; pc unchanged.
- SQUASH, ack=1: discard rdata; pc←pending (or redirect_pc if redirect=1 again); go REQ.
- SQUASH, ack=0: a new redirect overwrites pending; stay SQUASH.
- HOLD:
  - redirect=1: drop hold_instr; pc←redirect_pc; go REQ.
  - else stall=0: IF/ID←{1, hold_instr, pc+4}; pc←pc+4; go REQ.
  - else: stay HOLD.
- IF/ID update priority: redirect=1 → ifid_valid←0, other fields unchanged. Else stall=1 → hold all fields. Else a new instruction loads per the rules above. Else (no instruction delivered) → ifid_valid←0 (bubble).
- Redirect beats stall in every state.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0. pc[1:0] is always 0.

## Timing
- Zero-wait memory (ack in the request cycle): instruction appears in IF/ID one edge after the request. Throughput is 1 instruction/cycle.
- N-wait memory: IF/ID loads on the edge following the ack.
- Redirect to first target request: one edge, or on the edge after the squashed ack in SQUASH.
- First request after reset release: the same cycle inrst_n goes high, at addr RESET_PC.
- Reset asserted mid-request abandons it; outputs take reset values at that edge.

## Structure
- Shared package fetch_pkg holds:
  - state enum {REQ, HOLD, SQUASH}
  - PC_INC=32'd4
  - NOP_INSTR=32'h0000_0000
- Sub-module ifid_reg: IF/ID register with load/hold/flush controls, reused for the pipeline-register style. The FSM and PC logic stay in fetch_stage.

## Test plan
- Reset, then zero-wait memory returning addr-as-data: IF/ID shows instr 0,4,8 with pc4 4,8,12 on successive cycles; ifid_valid=1 from cycle 2.
- stall=1 for 3 cycles during ack at pc=8: IF/ID holds 4/pc4=8; state HOLD, imem_req=0. On release, IF/ID loads instr 8, pc4=12.
- 2-wait memory, redirect=1 to 0x100 one cycle after req at 0x10: the 0x10 response is discarded, the next req is at 0x100, and IF/ID never shows 0x10.
- redirect and stall together at pc=0x20 with ack: ifid_valid←0, pc←redirect target, and the stall is ignored for the flush.
- redirect_pc=0x203 gives pc=0x200. pc=0xFFFF_FFFC with ack gives pc=0 and ifid_pc4=0.
- inrst_n asserted during an outstanding wait-state request: next edge gives pc=RESET_PC, ifid_valid=0, imem_req=0 until release.
